seven_seg_scan_mux: RTL

//  - Upstream feeder for the BCD-to-7-segment decoder: time-multiplexes a 4-digit BCD

---
 rtl/seven_seg_scan_mux.sv | 100 ++++++++++
 1 files changed

// File: rtl/seven_seg_scan_mux.sv
// Time-multiplexes a shadowed 4-digit BCD word onto one 7-segment decoder with blanking gaps.
// Optional: define LEADING_ZERO_BLANK_EN to suppress leading zero digits (digit 0 always shown).
module seven_seg_scan_mux #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLANK_CYC   = 4,
  parameter int unsigned CNT_W       = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  output logic [3:0]  digit,
  output logic [3:0]  an,
  output logic        dp,
  output logic        tick
);

  logic [CNT_W-1:0] p_q, p_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      shadow_q, shadow_d;
  logic [3:0]       shadow_dp_q, shadow_dp_d;
  logic [3:0]       an_q, an_d;
  logic [3:0]       digit_q, digit_d;
  logic             dp_q, dp_d;
  logic             tick_q, tick_d;

  logic wrap;
  logic blank;
  logic suppress;

  // Outputs are computed from the post-edge state so a load or wrap shows on the same edge.
  always_comb begin
    wrap        = (p_q == CNT_W'(REFRESH_DIV - 1));
    p_d         = wrap ? '0 : p_q + 1'b1;
    idx_d       = wrap ? idx_q + 2'd1 : idx_q;
    shadow_d    = load ? value : shadow_q;
    shadow_dp_d = load ? dp_in : shadow_dp_q;
    tick_d      = wrap;
    blank       = (p_d < CNT_W'(BLANK_CYC));

    digit_d = 4'h0;
    unique case (idx_d)
      2'd0: digit_d = shadow_d[3:0];
      2'd1: digit_d = shadow_d[7:4];
      2'd2: digit_d = shadow_d[11:8];
      2'd3: digit_d = shadow_d[15:12];
      default: digit_d = 4'h0;
    endcase

    suppress = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    // A digit is leading-zero only if it and every higher digit is 0 with no dp requested.
    unique case (idx_d)
      2'd3: suppress = (shadow_d[15:12] == 4'h0) && !shadow_dp_d[3];
      2'd2: suppress = (shadow_d[15:8] == 8'h00) && (shadow_dp_d[3:2] == 2'b00);
      2'd1: suppress = (shadow_d[15:4] == 12'h000) && (shadow_dp_d[3:1] == 3'b000);
      default: suppress = 1'b0;
    endcase
`else
    suppress = 1'b0;
`endif

    if (blank || suppress) begin
      an_d = 4'b1111;
      dp_d = 1'b1;
    end else begin
      an_d = ~(4'b0001 << idx_d);
      dp_d = ~shadow_dp_d[idx_d];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_q         <= '0;
      idx_q       <= 2'd0;
      shadow_q    <= 16'h0000;
      shadow_dp_q <= 4'b0000;
      an_q        <= 4'b1111;
      digit_q     <= 4'h0;
      dp_q        <= 1'b1;
      tick_q      <= 1'b0;
    end else begin
      p_q         <= p_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      shadow_dp_q <= shadow_dp_d;
      an_q        <= an_d;
      digit_q     <= digit_d;
      dp_q        <= dp_d;
      tick_q      <= tick_d;
    end
  end

  assign digit = digit_q;
  assign an    = an_q;
  assign dp    = dp_q;
  assign tick  = tick_q;

endmodule
